// File: rtl/aes_rcon_sched.sv
// AES-128/192/256 key-schedule descriptor generator: one word index, rcon and RotWord/SubWord flag set per expanded word.
// All outputs are registered; rcon advances by GF(2^8) doubling after each j==0 word is accepted.
module aes_rcon_sched #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       key_len_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [5:0]       word_idx_o,
    output logic [OUT_W-1:0] rcon_o,
    output logic             rot_sub_o,
    output logic             sub_only_o,
    output logic             last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, n_state;
    logic [3:0] nk, n_nk;
    logic [5:0] last_idx, n_last_idx;
    logic [5:0] idx, n_idx;
    logic [2:0] j, n_j;
    logic [7:0] rcon, n_rcon;
    logic       n_err;
    logic       n_run;
    logic       n_rot_sub;
    logic [OUT_W-1:0] n_rcon_w;
    logic       xfer;

    assign xfer = valid_o && ready_i;

    always_comb begin
        n_state    = state;
        n_nk       = nk;
        n_last_idx = last_idx;
        n_idx      = idx;
        n_j        = j;
        n_rcon     = rcon;
        n_err      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (key_len_i == 2'b11) begin
                        n_err = 1'b1;
                    end else begin
                        n_state = RUN;
                        case (key_len_i)
                            2'b00:   begin n_nk = 4'd4; n_last_idx = 6'd43; end
                            2'b01:   begin n_nk = 4'd6; n_last_idx = 6'd51; end
                            default: begin n_nk = 4'd8; n_last_idx = 6'd59; end
                        endcase
                        n_idx  = {2'b00, n_nk};
                        n_j    = 3'd0;
                        n_rcon = 8'h01;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    if (last_o) begin
                        n_state = DONE;
                    end else begin
                        n_idx = idx + 6'd1;
                        n_j   = ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
                        if (j == 3'd0)
                            n_rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    end
                end
            end
            default: n_state = IDLE;
        endcase
    end

    // Output flops are loaded from next-state values so they line up with the internal registers.
    always_comb begin
        n_run     = (n_state == RUN);
        n_rot_sub = n_run && (n_j == 3'd0);
        n_rcon_w  = '0;
        if (n_rot_sub)
            n_rcon_w[OUT_W-1 -: 8] = n_rcon;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            nk         <= 4'd0;
            last_idx   <= 6'd0;
            idx        <= 6'd0;
            j          <= 3'd0;
            rcon       <= 8'h00;
            valid_o    <= 1'b0;
            word_idx_o <= 6'd0;
            rcon_o     <= '0;
            rot_sub_o  <= 1'b0;
            sub_only_o <= 1'b0;
            last_o     <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state      <= n_state;
            nk         <= n_nk;
            last_idx   <= n_last_idx;
            idx        <= n_idx;
            j          <= n_j;
            rcon       <= n_rcon;
            valid_o    <= n_run;
            word_idx_o <= n_run ? n_idx : 6'd0;
            rcon_o     <= n_rcon_w;
            rot_sub_o  <= n_rot_sub;
            sub_only_o <= n_run && (n_nk == 4'd8) && (n_j == 3'd4);
            last_o     <= n_run && (n_idx == n_last_idx);
            busy_o     <= (n_state != IDLE);
            done_o     <= (n_state == DONE);
            err_o      <= n_err;
        end
    end

endmodule

// File: tb/tb_aes_rcon_sched.sv
// Bench for aes_rcon_sched: directed sequence with random readiness, checked against an arithmetic key-schedule model.
module tb_aes_rcon_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  key_len_i;
    logic        ready_i;
    logic        valid_o;
    logic [5:0]  word_idx_o;
    logic [31:0] rcon_o;
    logic        rot_sub_o;
    logic        sub_only_o;
    logic        last_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    aes_rcon_sched #(.OUT_W(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .key_len_i(key_len_i), .ready_i(ready_i),
        .valid_o(valid_o), .word_idx_o(word_idx_o), .rcon_o(rcon_o), .rot_sub_o(rot_sub_o),
        .sub_only_o(sub_only_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // x^k reduced modulo the AES polynomial by long division
    function automatic logic [7:0] gf_pow2(input int k);
        int v;
        v = 1 << k;
        for (int b = 15; b >= 8; b--)
            if (((v >> b) & 1) != 0)
                v = v ^ (32'h11b << (b - 8));
        return 8'(v);
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_idx"},   32'(word_idx_o), 32'd0);
        chk({tag, "_rcon"},  rcon_o, 32'd0);
        chk({tag, "_flags"}, 32'({rot_sub_o, sub_only_o, last_o}), 32'd0);
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
        chk({tag, "_done"},  32'(done_o), 32'd0);
        chk({tag, "_err"},   32'(err_o), 32'd0);
    endtask

    // mode 0: ready held high, 1: random ready, 2: 3-cycle stall at i=8, 3: reset at i=20
    task automatic run_sched(input logic [1:0] kl, input int mode, input bit poke);
        int nk, last_i, i, cycles, stalls, valid_cycles;
        bit rot;
        logic [31:0] exp_rcon;
        nk = 4 + 2 * int'(kl);
        last_i = 4 * (nk + 6) + 3;
        start_i = 1'b1;
        key_len_i = kl;
        ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        i = nk;
        cycles = 0;
        stalls = 0;
        valid_cycles = 0;
        while (i <= last_i && cycles < 2000) begin
            rot = (i % nk) == 0;
            exp_rcon = rot ? {gf_pow2(i / nk - 1), 24'h0} : 32'h0;
            chk("valid", 32'(valid_o), 32'd1);
            chk("word_idx", 32'(word_idx_o), 32'(i));
            chk("rcon", rcon_o, exp_rcon);
            chk("rot_sub", 32'(rot_sub_o), 32'(rot));
            chk("sub_only", 32'(sub_only_o), 32'(nk == 8 && (i % nk) == 4));
            chk("last", 32'(last_o), 32'(i == last_i));
            chk("busy_done_err", 32'({busy_o, done_o, err_o}), 32'b100);
            if (valid_o) valid_cycles++;
            if (mode == 3 && i == 20) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk_idle_outputs("rst_mid");
                return;
            end
            case (mode)
                1: ready_i = ($urandom_range(0, 3) != 0);
                2: begin
                    ready_i = !(i == 8 && stalls < 3);
                    if (!ready_i) stalls++;
                end
                default: ready_i = 1'b1;
            endcase
            key_len_i = 2'($urandom);
            if (poke) start_i = 1'($urandom);
            @(negedge clk);
            cycles++;
            if (ready_i) i++;
        end
        start_i = 1'b0;
        chk("run_bound", 32'(cycles < 2000), 32'd1);
        if (mode == 0) chk("valid_cycles", 32'(valid_cycles), 32'(last_i - nk + 1));
        if (mode == 2) chk("stall_count", 32'(stalls), 32'd3);
        chk("done_pulse", 32'({valid_o, busy_o, done_o}), 32'b011);
        @(negedge clk);
        chk("after_done", 32'({valid_o, busy_o, done_o, err_o}), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        key_len_i = 2'b00;
        ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("reset");

        // illegal key length: error pulse only
        start_i = 1'b1;
        key_len_i = 2'b11;
        @(negedge clk);
        start_i = 1'b0;
        chk("err_pulse", 32'(err_o), 32'd1);
        chk("err_valid_busy", 32'({valid_o, busy_o}), 32'd0);
        @(negedge clk);
        chk_idle_outputs("err_after");

        run_sched(2'b00, 0, 1'b0);
        run_sched(2'b01, 1, 1'b1);
        run_sched(2'b10, 1, 1'b0);
        run_sched(2'b10, 0, 1'b1);
        run_sched(2'b00, 2, 1'b0);
        run_sched(2'b00, 3, 1'b0);
        @(negedge clk);
        chk_idle_outputs("idle_after_rst");
        run_sched(2'b00, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
